// File: rtl/mdu_ctrl.sv
// Iterative RV32M multiply/divide unit for the Execute stage: 32-step radix-2 datapath.
// Optional build macro MDU_FAST_MUL_EN switches multiplies to a single-cycle 33x33 signed multiplier.
`timescale 1ns/1ps
module mdu_ctrl (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startE,
    input  logic [2:0]  funct3E,
    input  logic [31:0] srcAE,
    input  logic [31:0] srcBE,
    input  logic        flushE,
    output logic        stallMdu,
    output logic        mduDone,
    output logic [31:0] mduResult,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;

    stateT       state;
    logic [4:0]  count;
    logic [63:0] work;
    logic [31:0] operand;
    logic [2:0]  op;
    logic        negRes;

    logic        isDivE, aSignedE, bSignedE, negAE, negBE;
    logic [31:0] magAE, magBE;
    logic        divZeroE, overflowE, accept;

    always_comb begin
        isDivE    = funct3E[2];
        aSignedE  = isDivE ? ~funct3E[0] : (funct3E[1:0] != 2'b11);
        bSignedE  = isDivE ? ~funct3E[0] : ~funct3E[1];
        negAE     = aSignedE & srcAE[31];
        negBE     = bSignedE & srcBE[31];
        magAE     = negAE ? -srcAE : srcAE;
        magBE     = negBE ? -srcBE : srcBE;
        divZeroE  = isDivE & (srcBE == '0);
        overflowE = isDivE & ~funct3E[0] & (srcAE == 32'h8000_0000) & (srcBE == '1);
    end

    assign accept   = (state == IDLE) & startE & ~flushE;
    assign stallMdu = accept | (state == CALC);
    assign busy     = (state != IDLE);

    // Multiply keeps the multiplier in work[31:0] and accumulates into the top half;
    // divide shifts the dividend left into a 33-bit partial remainder.
    logic [63:0] stepWork;
    logic [32:0] addSum, subDiff;

    always_comb begin
        addSum  = {1'b0, work[63:32]} + {1'b0, operand};
        subDiff = work[63:31] - {1'b0, operand};
        if (op[2]) begin
            if (!subDiff[32])
                stepWork = {subDiff[31:0], work[30:0], 1'b1};
            else
                stepWork = {work[62:0], 1'b0};
        end else if (work[0]) begin
            stepWork = {addSum, work[31:1]};
        end else begin
            stepWork = {1'b0, work[63:1]};
        end
    end

    logic [63:0] prodFinal;
    logic [31:0] quotFinal, remFinal, calcResult;

    always_comb begin
        prodFinal = negRes ? -stepWork : stepWork;
        quotFinal = negRes ? -stepWork[31:0] : stepWork[31:0];
        remFinal  = negRes ? -stepWork[63:32] : stepWork[63:32];
        case (op)
            3'b000:                 calcResult = prodFinal[31:0];
            3'b001, 3'b010, 3'b011: calcResult = prodFinal[63:32];
            3'b100, 3'b101:         calcResult = quotFinal;
            default:                calcResult = remFinal;
        endcase
    end

`ifdef MDU_FAST_MUL_EN
    logic [63:0] aExt, bExt, fastProd;
    logic [31:0] fastResult;

    always_comb begin
        aExt       = {{32{negAE}}, srcAE};
        bExt       = {{32{negBE}}, srcBE};
        fastProd   = aExt * bExt;
        fastResult = (funct3E[1:0] == 2'b00) ? fastProd[31:0] : fastProd[63:32];
    end
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            count     <= '0;
            work      <= '0;
            operand   <= '0;
            op        <= '0;
            negRes    <= 1'b0;
            mduResult <= '0;
            mduDone   <= 1'b0;
        end else begin
            mduDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op    <= funct3E;
                        count <= '0;
                        if (divZeroE) begin
                            mduResult <= funct3E[1] ? srcAE : '1;
                            mduDone   <= 1'b1;
                            state     <= DONE;
                        end else if (overflowE) begin
                            mduResult <= funct3E[1] ? '0 : 32'h8000_0000;
                            mduDone   <= 1'b1;
                            state     <= DONE;
                        end
`ifdef MDU_FAST_MUL_EN
                        else if (!funct3E[2]) begin
                            mduResult <= fastResult;
                            mduDone   <= 1'b1;
                            state     <= DONE;
                        end
`endif
                        else begin
                            work    <= funct3E[2] ? {32'b0, magAE} : {32'b0, magBE};
                            operand <= funct3E[2] ? magBE : magAE;
                            // remainder takes the dividend's sign, everything else A xor B
                            negRes  <= (funct3E[2] & funct3E[1]) ? negAE : (negAE ^ negBE);
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flushE) begin
                        state <= IDLE;
                    end else begin
                        work  <= stepWork;
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            mduResult <= calcResult;
                            mduDone   <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port resetN  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port startE  input  1  an M-extension op is valid in Execute.
REQ-004 SHALL have port funct3E  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port srcAE  input  32  operand A (multiplicand or dividend).
REQ-006 SHALL have port srcBE  input  32  operand B (multiplier or divisor).
REQ-007 SHALL have port flushE  input  1  Execute-stage flush from the hazard unit.
REQ-008 SHALL have port stallMdu  output  1  stall request for the F, D and E stages.
REQ-009 SHALL have port mduDone  output  1  one-cycle pulse; mduResult is valid.
REQ-010 SHALL have port mduResult  output  32  registered result.
REQ-011 SHALL have port busy  output  1  FSM is not in IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 In IDLE with startE=1 and flushE=0, SHALL latch operands and funct3E, clear the 5-bit iteration counter and enter CALC.
REQ-014 Operand handling:
- Signed ops SHALL operate on operand magnitudes.
- SHALL record the result sign: A xor B for product and quotient; sign of A for remainder.
REQ-015 stallMdu SHALL be combinational: (IDLE and startE and not flushE) or CALC; SHALL be 0 in DONE.
REQ-016 CALC SHALL perform one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide) over a 64-bit working register.
- Counter SHALL increment 0..31.
- SHALL enter DONE after the step at count 31.
REQ-017 On entry to DONE:
- mduResult SHALL be loaded: low 32 bits of the signed-corrected product for MUL; high 32 bits for MULH, MULHSU and MULHU; quotient for DIV/DIVU; remainder for REM/REMU.
- mduDone SHALL be 1 for that cycle.
- The FSM SHALL return to IDLE on the next edge.
REQ-018 Latency: start accepted in cycle T; CALC occupies T+1..T+32; DONE in T+33; stallMdu high T..T+32.
REQ-019 startE SHALL be ignored in DONE (it is the completing op).
- A new op SHALL be accepted no earlier than the IDLE cycle following DONE.
REQ-020 Divide by zero SHALL skip CALC and enter DONE at T+1.
- Quotient SHALL be 0xFFFFFFFF.
- Remainder SHALL be the dividend.
REQ-021 Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF) SHALL skip CALC and enter DONE at T+1.
- Quotient SHALL be 0x80000000.
- Remainder SHALL be 0.
REQ-022 flushE=1 in CALC SHALL abort to IDLE on the next edge.
- No mduDone SHALL be produced.
- mduResult SHALL be unchanged.
REQ-023 flushE=1 in IDLE SHALL block acceptance of a start in that cycle.
REQ-024 mduResult SHALL hold its value until the next DONE.

Reset
REQ-025 resetN=0 SHALL immediately force the following, including mid-CALC:
- FSM to IDLE.
- Counter to 0.
- Working register and mduResult to 0.
- mduDone, stallMdu and busy to 0.
REQ-026 After resetN deasserts, the first start SHALL be accepted on the first rising edge with startE=1.

Configuration
REQ-027 With macro MDU_FAST_MUL_EN defined, multiply ops SHALL use a single-cycle 33x33 signed multiply.
- They SHALL go IDLE->DONE with result at T+1 and stallMdu high only in T.
- Divide ops SHALL be unchanged.
REQ-028 Without MDU_FAST_MUL_EN, multiply ops SHALL use the iterative 32-cycle CALC path of REQ-016/REQ-018.

Verification
REQ-029 DIVU: A=100, B=7 -> stallMdu high 33 cycles; mduDone at T+33; mduResult=14; REMU on the same operands -> 2.
REQ-030 DIV: A=0xFFFFFFF9 (-7), B=2 -> quotient 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1).
REQ-031 DIVU: B=0, A=0x1234 -> mduDone at T+1, result 0xFFFFFFFF; REMU -> 0x1234. DIV: A=0x80000000, B=0xFFFFFFFF -> result 0x80000000 at T+1.
REQ-032 MULH: A=0x80000000, B=0x80000000 -> 0x40000000; MUL on the same operands -> 0x00000000. Latency T+33 without the macro and T+1 with MDU_FAST_MUL_EN.
REQ-033 Abort and reset:
- flushE pulsed at T+10 of a DIVU -> IDLE at T+11, no mduDone, busy=0.
- resetN pulsed low at T+5 -> all outputs 0 immediately.
REQ-034 Back-to-back: startE held high through DONE -> no re-acceptance in the DONE cycle; the next op is accepted in the following IDLE cycle.
